float_round_pack: RTL and testbench

- Back-end stage of the single-precision adder datapath. It consumes the raw sign, working exponent and extended sum fraction produced by the add stage.
- Normalizes the fraction, applies IEEE 754 round-to-nearest-even, renormalizes on rounding carry, checks overflow/underflow, and packs the 32-bit result.
- Multi-cycle FSM with a start/ack handshake, matching the add stage's handshake.

---
 rtl/float_round_pack.sv | 163 ++++++++++++++++
 tb/tb_float_round_pack.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/float_round_pack.sv
// Back end of the single-precision adder: normalize, round-to-nearest-even,
// renormalize, range check and pack one result per start/ack transaction.
module float_round_pack #(
   parameter int EXP_W = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    ack,
   input  logic                    sign_in,
   input  logic signed [EXP_W-1:0] exp_in,
   input  logic [27:0]             frac_in,
   output logic [31:0]             res,
   output logic                    done,
   output logic                    overflow,
   output logic                    underflow,
   output logic                    inexact,
   output logic [2:0]              dbg_state
);

   // Handshake: start is sampled only in IDLE, ack only in DONE; res and the
   // flags are valid while done is high and hold until the next CHECK.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_NORM   = 3'd1,
      S_ROUND  = 3'd2,
      S_RENORM = 3'd3,
      S_CHECK  = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   localparam logic signed [EXP_W-1:0] E_ONE  = EXP_W'(1);
   localparam logic signed [EXP_W-1:0] E_ZERO = EXP_W'(0);
   localparam logic signed [EXP_W-1:0] E_MAX  = EXP_W'(255);

   state_t                  r_state;
   state_t                  w_next;
   logic                    r_s;
   logic signed [EXP_W-1:0] r_e;
   logic [27:0]             r_f;
   logic                    r_z;
   logic                    r_rnd_inx;
   logic [31:0]             r_res;
   logic                    r_done;
   logic                    r_ovf;
   logic                    r_unf;
   logic                    r_inx;

   logic                    w_up;
   logic [24:0]             w_rounded;
   logic [31:0]             w_res;
   logic                    w_ovf;
   logic                    w_unf;
   logic                    w_inx;

   // RNE: round up on guard when anything below it is set or on an odd lsb
   assign w_up      = r_f[2] & (r_f[1] | r_f[0] | r_f[3]);
   assign w_rounded = r_f[27:3] + {24'd0, w_up};

   always_comb begin
      w_res = {r_s, r_e[7:0], r_f[25:3]};
      w_ovf = 1'b0;
      w_unf = 1'b0;
      w_inx = r_rnd_inx;
      if (r_z) begin
         w_res = {r_s, 31'd0};
         w_inx = 1'b0;
      end else if (r_e >= E_MAX) begin
         w_res = {r_s, 8'hFF, 23'd0};
         w_ovf = 1'b1;
         w_inx = 1'b1;
      end else if (r_e <= E_ZERO) begin
         w_res = {r_s, 31'd0};
         w_unf = 1'b1;
         w_inx = 1'b1;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (start) w_next = (frac_in == 28'd0) ? S_CHECK : S_NORM;
         S_NORM:   if (!r_f[27] && r_f[26]) w_next = S_ROUND;
         S_ROUND:  w_next = S_RENORM;
         S_RENORM: w_next = S_CHECK;
         S_CHECK:  w_next = S_DONE;
         S_DONE:   if (ack) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_s       <= 1'b0;
         r_e       <= E_ZERO;
         r_f       <= 28'd0;
         r_z       <= 1'b0;
         r_rnd_inx <= 1'b0;
         r_res     <= 32'd0;
         r_done    <= 1'b0;
         r_ovf     <= 1'b0;
         r_unf     <= 1'b0;
         r_inx     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_s       <= sign_in;
                  r_e       <= exp_in;
                  r_f       <= frac_in;
                  r_z       <= (frac_in == 28'd0);
                  r_rnd_inx <= 1'b0;
               end
            end
            S_NORM: begin
               // Right shift folds the dropped bit into sticky
               if (r_f[27]) begin
                  r_f <= {1'b0, r_f[27:2], r_f[1] | r_f[0]};
                  r_e <= r_e + E_ONE;
               end else if (!r_f[26]) begin
                  r_f <= {r_f[26:0], 1'b0};
                  r_e <= r_e - E_ONE;
               end
            end
            S_ROUND: begin
               r_f       <= {w_rounded, 3'b000};
               r_rnd_inx <= |r_f[2:0];
            end
            S_RENORM: begin
               if (r_f[27]) begin
                  r_f <= {1'b0, r_f[27:1]};
                  r_e <= r_e + E_ONE;
               end
            end
            S_CHECK: begin
               r_res  <= w_res;
               r_ovf  <= w_ovf;
               r_unf  <= w_unf;
               r_inx  <= w_inx;
               r_done <= 1'b1;
            end
            S_DONE: begin
               if (ack) r_done <= 1'b0;
            end
            default: r_done <= 1'b0;
         endcase
      end
   end

   assign res       = r_res;
   assign done      = r_done;
   assign overflow  = r_ovf;
   assign underflow = r_unf;
   assign inexact   = r_inx;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_float_round_pack.sv
// Bench for float_round_pack: directed vector table, handshake/reset
// sequences and randomized operations against an arithmetic reference model.
module tb_float_round_pack;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               start = 1'b0;
   logic               ack = 1'b0;
   logic               sign_in = 1'b0;
   logic signed [9:0]  exp_in = '0;
   logic [27:0]        frac_in = '0;
   logic [31:0]        res;
   logic               done;
   logic               overflow;
   logic               underflow;
   logic               inexact;
   logic [2:0]         dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   float_round_pack #(.EXP_W(10)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .ack       (ack),
      .sign_in   (sign_in),
      .exp_in    (exp_in),
      .frac_in   (frac_in),
      .res       (res),
      .done      (done),
      .overflow  (overflow),
      .underflow (underflow),
      .inexact   (inexact),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic              sg;
      logic signed [9:0] ex;
      logic [27:0]       fr;
      logic [31:0]       res;
      logic              ovf;
      logic              unf;
      logic              inx;
      int                lat;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
      end
   endtask

   // Reference: value = frac * 2^(exp-127-26); normalize by MSB position,
   // round the 3 dropped bits to nearest-even, then range-check.
   task automatic model(input logic sg, input logic signed [9:0] ex, input logic [27:0] fr,
                        output logic [31:0] r, output logic o, output logic u,
                        output logic x, output int lat);
      int    e;
      int    p;
      int    k;
      longint f;
      longint keep;
      longint rem;
      e = ex;
      o = 1'b0; u = 1'b0; x = 1'b0;
      if (fr == 28'd0) begin
         r = {sg, 31'd0};
         lat = 1;
         return;
      end
      p = 27;
      while (!fr[p]) p--;
      if (p == 27) begin
         f = longint'(fr >> 1) | longint'(fr & 28'd1);
         e = e + 1;
         k = 1;
      end else begin
         k = 26 - p;
         f = longint'(fr) << k;
         e = e - k;
      end
      keep = f >> 3;
      rem  = f & 7;
      x    = (rem != 0);
      if (rem > 4 || (rem == 4 && (keep % 2) == 1)) keep = keep + 1;
      if (keep == (longint'(1) << 24)) begin
         keep = keep >> 1;
         e = e + 1;
      end
      if (e >= 255) begin
         r = {sg, 8'hFF, 23'd0};
         o = 1'b1;
         x = 1'b1;
      end else if (e <= 0) begin
         r = {sg, 31'd0};
         u = 1'b1;
         x = 1'b1;
      end else begin
         r = {sg, 8'(e), 23'(keep)};
      end
      lat = 4 + k;
   endtask

   // Drives one transaction, returns what the DUT presented and the latency
   // counted in edges after the capture edge; acks and checks done drops.
   task automatic apply_op(input logic sg, input logic signed [9:0] ex, input logic [27:0] fr,
                           input logic ack_at_start, input string tag,
                           output logic [31:0] r, output logic o, output logic u,
                           output logic x, output int lat);
      bit got;
      @(negedge clk);
      start = 1'b1; sign_in = sg; exp_in = ex; frac_in = fr; ack = ack_at_start;
      @(posedge clk); #1;
      start = 1'b0; ack = 1'b0;
      lat = 0; got = 0;
      while (!got && lat < 64) begin
         @(posedge clk); #1;
         lat++;
         if (done) got = 1;
      end
      r = res; o = overflow; u = underflow; x = inexact;
      @(negedge clk); ack = 1'b1;
      @(posedge clk); #1; ack = 1'b0;
      check({tag, "_done_drop"}, {31'd0, done}, 32'd0);
   endtask

   task automatic compare_op(input string tag, input logic [31:0] r, input logic o, input logic u,
                             input logic x, input int lat, input logic [31:0] er, input logic eo,
                             input logic eu, input logic ex_, input int elat);
      check({tag, "_res"}, r, er);
      check({tag, "_ovf"}, {31'd0, o}, {31'd0, eo});
      check({tag, "_unf"}, {31'd0, u}, {31'd0, eu});
      check({tag, "_inx"}, {31'd0, x}, {31'd0, ex_});
      check({tag, "_lat"}, 32'(lat), 32'(elat));
   endtask

   initial begin
      logic [31:0]       r, er, tmp;
      logic              o, u, x, eo, eu, ex_;
      int                lat, elat, p, ev;
      logic              sg;
      logic signed [9:0] exv;
      logic [27:0]       fr;

      vecs[0] = '{1'b0, 10'sd127, 28'h4000000, 32'h3F800000, 1'b0, 1'b0, 1'b0, 4};
      vecs[1] = '{1'b0, 10'sd127, 28'h8000000, 32'h40000000, 1'b0, 1'b0, 1'b0, 5};
      vecs[2] = '{1'b0, 10'sd127, 28'h400000C, 32'h3F800002, 1'b0, 1'b0, 1'b1, 4};
      vecs[3] = '{1'b0, 10'sd127, 28'h4000004, 32'h3F800000, 1'b0, 1'b0, 1'b1, 4};
      vecs[4] = '{1'b0, 10'sd127, 28'h7FFFFFC, 32'h40000000, 1'b0, 1'b0, 1'b1, 4};
      vecs[5] = '{1'b0, 10'sd254, 28'h7FFFFFC, 32'h7F800000, 1'b1, 1'b0, 1'b1, 4};
      vecs[6] = '{1'b0, 10'sd2,   28'h0800000, 32'h00000000, 1'b0, 1'b1, 1'b1, 7};
      vecs[7] = '{1'b1, 10'sd127, 28'h0000000, 32'h80000000, 1'b0, 1'b0, 1'b0, 1};

      // Clock/reset
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_res", res, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_flags", {29'd0, overflow, underflow, inexact}, 32'd0);
      check("reset_state", {29'd0, dbg_state}, 32'd0);
      @(negedge clk); rst = 1'b1;

      // Directed table
      foreach (vecs[i]) begin
         apply_op(vecs[i].sg, vecs[i].ex, vecs[i].fr, 1'b0, $sformatf("vec%0d", i), r, o, u, x, lat);
         compare_op($sformatf("vec%0d", i), r, o, u, x, lat,
                    vecs[i].res, vecs[i].ovf, vecs[i].unf, vecs[i].inx, vecs[i].lat);
      end

      // Hold in DONE with ack low: outputs stable, new start ignored
      @(negedge clk);
      start = 1'b1; sign_in = 1'b0; exp_in = 10'sd127; frac_in = 28'h400000C;
      @(posedge clk); #1;
      sign_in = 1'b1; exp_in = 10'sd3; frac_in = 28'h0000001;
      lat = 0;
      while (!done && lat < 64) begin
         @(posedge clk); #1;
         lat++;
      end
      check("hold_lat", 32'(lat), 32'd4);
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         check($sformatf("hold_res_%0d", c), res, 32'h3F800002);
         check($sformatf("hold_done_%0d", c), {31'd0, done}, 32'd1);
      end
      @(negedge clk); start = 1'b0; ack = 1'b1;
      @(posedge clk); #1; ack = 1'b0;
      check("hold_ack_done", {31'd0, done}, 32'd0);
      check("hold_ack_state", {29'd0, dbg_state}, 32'd0);

      // Reset during NORM (26 left shifts pending) aborts the operation
      @(negedge clk);
      start = 1'b1; sign_in = 1'b0; exp_in = 10'sd100; frac_in = 28'h0000001;
      @(posedge clk); #1; start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      check("abort_res", res, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_state", {29'd0, dbg_state}, 32'd0);
      @(negedge clk); rst = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      check("abort_no_result", {31'd0, done}, 32'd0);
      apply_op(1'b0, 10'sd127, 28'h4000000, 1'b0, "after_abort", r, o, u, x, lat);
      compare_op("after_abort", r, o, u, x, lat, 32'h3F800000, 1'b0, 1'b0, 1'b0, 4);

      // Randomized against the reference model; ack sometimes raised with start
      for (int n = 0; n < 150; n++) begin
         sg = 1'($urandom_range(0, 1));
         ev = int'($urandom_range(0, 400)) - 100;
         exv = 10'(ev);
         p = $urandom_range(0, 27);
         tmp = $urandom & ((32'd1 << (p + 1)) - 32'd1);
         tmp = tmp | (32'd1 << p);
         fr = tmp[27:0];
         if ($urandom_range(0, 3) == 0) fr[2:0] = 3'b100;
         if ($urandom_range(0, 15) == 0) fr = 28'd0;
         model(sg, exv, fr, er, eo, eu, ex_, elat);
         apply_op(sg, exv, fr, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n), r, o, u, x, lat);
         compare_op($sformatf("rnd%0d", n), r, o, u, x, lat, er, eo, eu, ex_, elat);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
